// File: rtl/pkt_capture_buffer.sv
`timescale 1ns/1ps
// pkt_capture_buffer
//   Captures one whole packet from the 64-bit data/ctrl stream into an on-chip
//   buffer. It then lends the buffer to the processing pipeline for in-place
//   edits, and finally streams the (possibly modified) packet downstream.
//   Exactly one packet is resident at a time: receive -> process -> send.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_ctrl/in_wr upstream word, ctrl (0 = payload) and valid
//   in_rdy                buffer accepts words (IDLE/RECV only)
//   out_data/out_ctrl     downstream word (registered)
//   out_wr                downstream valid, only asserted while out_rdy is high
//   out_rdy               downstream may accept
//   proc_addr/proc_we     pipeline buffer address / data-field write enable
//   proc_wdata            pipeline write data (ctrl field is never touched)
//   proc_rdata            pipeline read data, one cycle after proc_addr
//   proc_done             pulse: processing complete, start sending
//   pkt_ready             high while the pipeline owns the buffer
//   pkt_len               number of stored words
//   overflow              current packet was truncated
//   pkt_count             packets fully sent (wraps)
module pkt_capture_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic [ADDR_WIDTH-1:0] proc_addr,
  input  logic                  proc_we,
  input  logic [DATA_WIDTH-1:0] proc_wdata,
  output logic [DATA_WIDTH-1:0] proc_rdata,
  input  logic                  proc_done,
  output logic                  pkt_ready,
  output logic [ADDR_WIDTH:0]   pkt_len,
  output logic                  overflow,
  output logic [31:0]           pkt_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   LEN_FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, RECV, PROC, SEND} state_t;
  state_t state, state_nxt;

  // Data and ctrl kept in separate arrays so pipeline writes leave ctrl intact.
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [CTRL_WIDTH-1:0] ctrl_mem [DEPTH];

  logic                  accept, eop, len_full, seen_payload;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [ADDR_WIDTH:0]   rd_ptr, sent_cnt;
  logic                  issue, vld_p0, vld_p1, take_p1, adv_p0, xfer, last_xfer;
  logic [DATA_WIDTH-1:0] rdata_p0;
  logic [CTRL_WIDTH-1:0] rctrl_p0;

  assign in_rdy    = rst_n && (state == IDLE || state == RECV);
  assign accept    = in_wr && in_rdy;
  assign len_full  = (pkt_len == LEN_FULL);
  // Leading header words (ctrl != 0 before any payload) never end a packet.
  assign eop       = accept && (state == RECV) && (in_ctrl != '0) && seen_payload;
  assign wr_addr   = (state == IDLE) ? '0 : pkt_len[ADDR_WIDTH-1:0];
  assign rd_addr   = rd_ptr[ADDR_WIDTH-1:0];
  assign pkt_ready = (state == PROC);

  // Send path: p0 = RAM read register, p1 = output register. A new read is
  // issued only when p0 is empty or moving on, so a stalled word is never
  // overwritten (p0 acts as the skid entry).
  assign xfer      = vld_p1 && out_rdy;
  assign out_wr    = xfer;
  assign take_p1   = !vld_p1 || out_rdy;
  assign adv_p0    = vld_p0 && take_p1;
  assign issue     = (state == SEND) && (rd_ptr < pkt_len) && (!vld_p0 || adv_p0);
  assign last_xfer = xfer && (sent_cnt == pkt_len - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RECV;
      RECV:    if (eop)       state_nxt = PROC;
      PROC:    if (proc_done) state_nxt = SEND;
      SEND:    if (last_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_len      <= '0;
      overflow     <= 1'b0;
      seen_payload <= 1'b0;
      pkt_count    <= '0;
      rd_ptr       <= '0;
      sent_cnt     <= '0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          pkt_len      <= {{ADDR_WIDTH{1'b0}}, 1'b1};
          overflow     <= 1'b0;
          seen_payload <= (in_ctrl == '0);
        end
        RECV: if (accept) begin
          if (!len_full) pkt_len  <= pkt_len + 1'b1;
          else           overflow <= 1'b1;
          if (in_ctrl == '0) seen_payload <= 1'b1;
        end
        PROC: if (proc_done) begin
          rd_ptr   <= '0;
          sent_cnt <= '0;
        end
        SEND: begin
          if (issue) rd_ptr   <= rd_ptr + 1'b1;
          if (xfer)  sent_cnt <= sent_cnt + 1'b1;
          if (last_xfer) begin
            pkt_count <= pkt_count + 32'd1;
            pkt_len   <= '0;
          end
        end
        default: ;
      endcase
      // ---- p0 -> p1 stage boundary ----
      vld_p0 <= issue || (vld_p0 && !take_p1);
      if (adv_p0)    vld_p1 <= 1'b1;
      else if (xfer) vld_p1 <= 1'b0;
    end
  end

  // Buffer RAM and its read register; intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept && !len_full) begin
      data_mem[wr_addr] <= in_data;
      ctrl_mem[wr_addr] <= in_ctrl;
    end else if (eop && len_full) begin
      // Truncated packet: mark the last stored word as the end of packet.
      ctrl_mem[LAST_ADDR] <= CTRL_WIDTH'(1);
    end
    if (state == PROC && proc_we) data_mem[proc_addr] <= proc_wdata;
    // ---- read issue -> p0 stage boundary ----
    if (issue) begin
      rdata_p0 <= data_mem[rd_addr];
      rctrl_p0 <= ctrl_mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_ctrl   <= '0;
      proc_rdata <= '0;
    end else begin
      if (adv_p0) begin
        out_data <= rdata_p0;
        out_ctrl <= rctrl_p0;
      end
      // Read-before-write: a same-cycle proc_we returns the old word.
      if (state == PROC) proc_rdata <= data_mem[proc_addr];
    end
  end

endmodule

// File: tb/tb_pkt_capture_buffer.sv
`timescale 1ns/1ps
module tb_pkt_capture_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_wr, out_rdy, proc_we, proc_done, sel4;
  logic [63:0] in_data, proc_wdata;
  logic [7:0]  in_ctrl, proc_addr;

  logic        in_rdy8, out_wr8, pkt_ready8, overflow8;
  logic [63:0] out_data8, proc_rdata8;
  logic [7:0]  out_ctrl8;
  logic [8:0]  pkt_len8;
  logic [31:0] pkt_count8;

  logic        in_rdy4, out_wr4, pkt_ready4, overflow4;
  logic [63:0] out_data4, proc_rdata4;
  logic [7:0]  out_ctrl4;
  logic [4:0]  pkt_len4;
  logic [31:0] pkt_count4;

  pkt_capture_buffer #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr & ~sel4), .in_rdy(in_rdy8),
    .out_data(out_data8), .out_ctrl(out_ctrl8), .out_wr(out_wr8), .out_rdy(out_rdy),
    .proc_addr(proc_addr), .proc_we(proc_we & ~sel4), .proc_wdata(proc_wdata),
    .proc_rdata(proc_rdata8), .proc_done(proc_done & ~sel4),
    .pkt_ready(pkt_ready8), .pkt_len(pkt_len8), .overflow(overflow8), .pkt_count(pkt_count8)
  );

  pkt_capture_buffer #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .ADDR_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr & sel4), .in_rdy(in_rdy4),
    .out_data(out_data4), .out_ctrl(out_ctrl4), .out_wr(out_wr4), .out_rdy(out_rdy),
    .proc_addr(proc_addr[3:0]), .proc_we(proc_we & sel4), .proc_wdata(proc_wdata),
    .proc_rdata(proc_rdata4), .proc_done(proc_done & sel4),
    .pkt_ready(pkt_ready4), .pkt_len(pkt_len4), .overflow(overflow4), .pkt_count(pkt_count4)
  );

  // Observed signals of whichever instance is selected.
  logic        in_rdy_m, out_wr_m, pkt_ready_m, overflow_m;
  logic [63:0] out_data_m, proc_rdata_m;
  logic [7:0]  out_ctrl_m;
  logic [8:0]  pkt_len_m;
  logic [31:0] pkt_count_m;
  assign in_rdy_m     = sel4 ? in_rdy4     : in_rdy8;
  assign out_wr_m     = sel4 ? out_wr4     : out_wr8;
  assign pkt_ready_m  = sel4 ? pkt_ready4  : pkt_ready8;
  assign overflow_m   = sel4 ? overflow4   : overflow8;
  assign out_data_m   = sel4 ? out_data4   : out_data8;
  assign out_ctrl_m   = sel4 ? out_ctrl4   : out_ctrl8;
  assign proc_rdata_m = sel4 ? proc_rdata4 : proc_rdata8;
  assign pkt_len_m    = sel4 ? {4'b0, pkt_len4} : pkt_len8;
  assign pkt_count_m  = sel4 ? pkt_count4  : pkt_count8;

  typedef struct {
    logic [63:0] d;   // input data
    logic [7:0]  c;   // input ctrl
    logic [63:0] ed;  // expected output data
    logic [7:0]  ec;  // expected output ctrl
  } vec_t;
  vec_t tbl[64];

  int checks = 0;
  int failures = 0;
  logic [63:0] got_d[64];
  logic [7:0]  got_c[64];
  bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input int base, input int n);
    for (int j = 0; j < n; j++)
      tbl[base+j].c = (j == 0) ? 8'hFF : (j == n-1) ? 8'h80 : 8'h00;
  endtask

  // Present words base..base+n-1, each held until accepted.
  task automatic drive_pkt(input int base, input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      in_wr = 1'b1;
      in_data = tbl[base+i].d;
      in_ctrl = tbl[base+i].c;
      k = 0;
      @(negedge clk);
      while (!in_rdy_m && k < 300) begin
        @(negedge clk);
        k++;
      end
      if (k >= 300) begin
        chk("in_accept_timeout", 64'(k), 64'd0);
        in_wr = 1'b0;
        return;
      end
      tick();
    end
    in_wr = 1'b0;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!pkt_ready_m && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("pkt_ready_timeout", {63'd0, pkt_ready_m}, 64'd1);
  endtask

  task automatic pulse_done(input int dly);
    repeat (dly) tick();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
  endtask

  // Collect output words (called right after SEND is entered). With stop_after
  // > 0 it returns once that many words have been seen.
  task automatic collect(input int base, input int n, input bit toggle, input int stop_after);
    int k, got, first_k, viol, extra;
    k = 0; got = 0; first_k = -1; viol = 0; extra = 0;
    for (int i = 0; i < 64; i++) begin
      got_d[i] = '0;
      got_c[i] = '0;
    end
    out_rdy = 1'b1;
    while (got < n && k < 300) begin
      @(negedge clk);
      k++;
      if (out_wr_m) begin
        if (!out_rdy) viol++;
        if (got < 64) begin
          got_d[got] = out_data_m;
          got_c[got] = out_ctrl_m;
        end
        got++;
        if (first_k < 0) first_k = k;
      end
      if (stop_after > 0 && got >= stop_after) begin
        for (int i = 0; i < stop_after; i++) begin
          chk($sformatf("word%0d_data", base+i), got_d[i], tbl[base+i].ed);
          chk($sformatf("word%0d_ctrl", base+i), 64'(got_c[i]), 64'(tbl[base+i].ec));
        end
        return;
      end
      tick();
      out_rdy = toggle ? pat[k % 6] : 1'b1;
    end
    out_rdy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_wr_m) extra++;
      tick();
    end
    chk($sformatf("pkt%0d_word_count", base), 64'(got + extra), 64'(n));
    chk($sformatf("pkt%0d_no_wr_without_rdy", base), 64'(viol), 64'd0);
    chk($sformatf("pkt%0d_first_latency_ge3", base), 64'(first_k >= 3), 64'd1);
    for (int i = 0; i < n && i < 64; i++) begin
      chk($sformatf("word%0d_data", base+i), got_d[i], tbl[base+i].ed);
      chk($sformatf("word%0d_ctrl", base+i), 64'(got_c[i]), 64'(tbl[base+i].ec));
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int extra;
    rst_n = 1'b0; in_wr = 1'b0; in_data = '0; in_ctrl = '0; out_rdy = 1'b1;
    proc_we = 1'b0; proc_done = 1'b0; proc_addr = '0; proc_wdata = '0; sel4 = 1'b0;

    // Packet table: A 0..7, B 8..15, C 16..35 (overflow), D 36..43,
    // E 44..46, F 47..50 (two headers), G 51..54.
    for (int i = 0; i < 64; i++) begin
      tbl[i].d = {8'h5A, i[7:0], 16'hBEEF, 32'(i * 7 + 3)};
      tbl[i].c = 8'h00;
    end
    set_ctrl(0, 8); set_ctrl(8, 8); set_ctrl(16, 20); set_ctrl(36, 8);
    set_ctrl(44, 3); set_ctrl(47, 4); set_ctrl(51, 4);
    tbl[48].c = 8'hFF;
    for (int i = 0; i < 64; i++) begin
      tbl[i].ed = tbl[i].d;
      tbl[i].ec = tbl[i].c;
    end
    tbl[11].ed = 64'hDEADBEEF_00000001;
    tbl[31].ec = 8'h01;

    // Reset state
    tick(); tick();
    chk("rst_in_rdy",     {63'd0, in_rdy_m},    64'd0);
    chk("rst_out_wr",     {63'd0, out_wr_m},    64'd0);
    chk("rst_out_data",   out_data_m,           64'd0);
    chk("rst_out_ctrl",   64'(out_ctrl_m),      64'd0);
    chk("rst_pkt_ready",  {63'd0, pkt_ready_m}, 64'd0);
    chk("rst_pkt_len",    64'(pkt_len_m),       64'd0);
    chk("rst_overflow",   {63'd0, overflow_m},  64'd0);
    chk("rst_pkt_count",  64'(pkt_count_m),     64'd0);
    chk("rst_proc_rdata", proc_rdata_m,         64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_in_rdy", {63'd0, in_rdy_m}, 64'd1);

    // A: basic capture / pass-through
    drive_pkt(0, 8);
    chk("A_pkt_ready", {63'd0, pkt_ready_m}, 64'd1);
    chk("A_in_rdy_proc", {63'd0, in_rdy_m}, 64'd0);
    chk("A_pkt_len", 64'(pkt_len_m), 64'd8);
    chk("A_overflow", {63'd0, overflow_m}, 64'd0);
    pulse_done(5);
    chk("A_in_rdy_send", {63'd0, in_rdy_m}, 64'd0);
    chk("A_pkt_ready_send", {63'd0, pkt_ready_m}, 64'd0);
    collect(0, 8, 1'b0, 0);
    chk("A_pkt_count", 64'(pkt_count_m), 64'd1);
    chk("A_pkt_len_idle", 64'(pkt_len_m), 64'd0);
    chk("A_in_rdy_idle", {63'd0, in_rdy_m}, 64'd1);

    // B: pipeline read, write together with done, toggling out_rdy
    drive_pkt(8, 8);
    wait_ready();
    proc_addr = 8'd3;
    tick();
    chk("B_proc_rdata", proc_rdata_m, tbl[11].d);
    proc_we = 1'b1; proc_wdata = 64'hDEADBEEF_00000001; proc_done = 1'b1;
    tick();
    proc_we = 1'b0; proc_done = 1'b0;
    collect(8, 8, 1'b1, 0);
    chk("B_proc_rdata_held", proc_rdata_m, tbl[11].d);
    chk("B_pkt_count", 64'(pkt_count_m), 64'd2);

    // C: 20-word packet into a 16-word buffer
    sel4 = 1'b1;
    drive_pkt(16, 20);
    wait_ready();
    chk("C_overflow", {63'd0, overflow_m}, 64'd1);
    chk("C_pkt_len", 64'(pkt_len_m), 64'd16);
    pulse_done(2);
    collect(16, 16, 1'b0, 0);
    chk("C_pkt_count", 64'(pkt_count_m), 64'd1);
    sel4 = 1'b0;

    // D: reset in the middle of SEND
    drive_pkt(36, 8);
    wait_ready();
    pulse_done(1);
    collect(36, 8, 1'b0, 3);
    tick();
    rst_n = 1'b0;
    #1;
    chk("D_rst_out_wr", {63'd0, out_wr_m}, 64'd0);
    chk("D_rst_in_rdy", {63'd0, in_rdy_m}, 64'd0);
    chk("D_rst_pkt_count", 64'(pkt_count_m), 64'd0);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_wr_m) extra++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      @(negedge clk);
      if (out_wr_m) extra++;
    end
    chk("D_no_wr_after_rst", 64'(extra), 64'd0);
    tick();

    // E: short packet after the abandoned one
    drive_pkt(44, 3);
    wait_ready();
    chk("E_pkt_len", 64'(pkt_len_m), 64'd3);
    pulse_done(1);
    collect(44, 3, 1'b0, 0);
    chk("E_pkt_count", 64'(pkt_count_m), 64'd1);

    // F/G: second packet presented while the first is being sent
    reset_dut();
    drive_pkt(47, 4);
    wait_ready();
    chk("F_pkt_len", 64'(pkt_len_m), 64'd4);
    fork
      begin
        pulse_done(1);
        collect(47, 4, 1'b0, 0);
      end
      begin
        tick();
        tick();
        chk("G_stalled_in_rdy", {63'd0, in_rdy_m}, 64'd0);
        drive_pkt(51, 4);
      end
    join
    wait_ready();
    chk("G_pkt_len", 64'(pkt_len_m), 64'd4);
    pulse_done(1);
    collect(51, 4, 1'b0, 0);
    chk("G_pkt_count", 64'(pkt_count_m), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
